// File: rtl/pwm_motor_input_capture.sv
// Per-channel PWM high-time/period capture with timeout detection and a 1-cycle read port.
// Optional glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_motor_input_capture #(
  parameter int unsigned C_S_AXI_ACLK_FREQ_HZ = 100000000,
  parameter int unsigned NUMBER_OF_CHANNELS   = 4,
  parameter int unsigned ADDR_WIDTH           = 7,
  parameter int unsigned TIMEOUT_CYCLES       = 10000000,
  parameter int unsigned FILTER_CYCLES        = 4
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [NUMBER_OF_CHANNELS-1:0] MOTOR_IN,
  input  logic                          rd_en,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [31:0]                   rd_data,
  output logic                          rd_valid,
  output logic [NUMBER_OF_CHANNELS-1:0] CAPTURE_STB
);
  localparam int unsigned N  = NUMBER_OF_CHANNELS;
  localparam int unsigned WW = ADDR_WIDTH - 2;

  logic [N-1:0]  sync1_q, sync2_q, prev_q, lvl, rise, fall, tmo;
  logic [31:0]   cnt_q [N];
  logic [31:0]   width_q [N];
  logic [31:0]   period_q [N];
  logic [N-1:0]  armed_q, valid_q, lost_q, stb_q;
  logic [31:0]   rd_data_q;
  logic          rd_valid_q;
  logic [WW-1:0] word;
  logic          status_rd;
  logic [31:0]   status, rd_mux;

  // The synchronizer keeps tracking the pins through reset so that a level
  // already present at reset release is not mistaken for a fresh edge.
  always_ff @(posedge S_AXI_ACLK) begin
    sync1_q <= MOTOR_IN;
    sync2_q <= sync1_q;
    prev_q  <= lvl;
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned FCW = $clog2(FILTER_CYCLES + 1);
  logic [N-1:0]   filt_q;
  logic [FCW-1:0] fcnt_q [N];
  logic           unused_w;

  always_ff @(posedge S_AXI_ACLK) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCW'(FILTER_CYCLES - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end else begin
        fcnt_q[i] <= '0;
      end
    end
  end
  assign lvl      = filt_q;
  assign unused_w = ^rd_addr[1:0];
`else
  logic unused_w;
  assign lvl      = sync2_q;
  assign unused_w = ^{rd_addr[1:0], FILTER_CYCLES};
`endif

  assign rise      = lvl & ~prev_q;
  assign fall      = ~lvl & prev_q;
  assign word      = rd_addr[ADDR_WIDTH-1:2];
  assign status_rd = rd_en && (word == WW'(2));

  always_comb begin
    tmo = '0;
    for (int unsigned i = 0; i < N; i++) begin
      tmo[i] = (cnt_q[i] == TIMEOUT_CYCLES) && !rise[i];
    end
  end

  always_comb begin
    status         = '0;
    status[N-1:0]  = valid_q;
    status[16+:N]  = lost_q;
    rd_mux         = '0;
    if (word == WW'(0)) rd_mux = C_S_AXI_ACLK_FREQ_HZ;
    if (word == WW'(1)) rd_mux = N;
    if (word == WW'(2)) rd_mux = status;
    for (int unsigned i = 0; i < N; i++) begin
      if (word == WW'(8 + i))  rd_mux = width_q[i];
      if (word == WW'(16 + i)) rd_mux = period_q[i];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      armed_q    <= '0;
      valid_q    <= '0;
      lost_q     <= '0;
      stb_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i]    <= '0;
        width_q[i]  <= '0;
        period_q[i] <= '0;
      end
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_mux;
      stb_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        // A lost event in the same cycle as a STATUS read keeps the bit set.
        lost_q[i] <= (lost_q[i] & ~status_rd) | tmo[i];
        if (rise[i]) begin
          cnt_q[i]   <= 32'd1;
          armed_q[i] <= 1'b1;
          if (armed_q[i]) begin
            period_q[i] <= cnt_q[i];
            stb_q[i]    <= 1'b1;
            valid_q[i]  <= 1'b1;
          end
        end else begin
          if (cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 32'd1;
          if (tmo[i]) begin
            valid_q[i]  <= 1'b0;
            armed_q[i]  <= 1'b0;
            width_q[i]  <= '0;
            period_q[i] <= '0;
          end else if (fall[i] && armed_q[i]) begin
            // Unarmed falls belong to a pulse whose start was never seen.
            width_q[i] <= cnt_q[i];
          end
        end
      end
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign CAPTURE_STB = stb_q;
endmodule
